// File: rtl/alu_normalize_if.sv
// Request/response bundle for the iterative normalizer: operand and direction in,
// shift amount, normalized operand and zero flag out, valid/ready on both sides.
interface alu_normalize_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic            i_valid;
  logic            o_ready;
  logic            i_direction;
  logic [XLEN-1:0] i_a;
  logic            o_valid;
  logic            i_ready;
  logic [CW-1:0]   o_count;
  logic [XLEN-1:0] o_result;
  logic            o_zero;

  modport slave (
    input  i_valid,
    input  i_direction,
    input  i_a,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_count,
    output o_result,
    output o_zero
  );

  modport master (
    output i_valid,
    output i_direction,
    output i_a,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_count,
    input  o_result,
    input  o_zero
  );
endinterface

// File: rtl/alu_normalize.sv
// Iterative normalizer: scans STEP bits per cycle for the first set bit from the top
// (left) or bottom (right), returning the shift amount and the normalized operand.
module alu_normalize #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  alu_normalize_if.slave      bus_io
);
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   count_q, count_d;
  logic            dir_q, dir_d;
  logic            zero_q, zero_d;

  logic [STEP-1:0] win;
  logic            win_zero;
  logic [CW-1:0]   lz;
  logic [CW-1:0]   amt;
  logic            found;

  // Zeros counted from the scan-facing end of the window; equals STEP when empty.
  always_comb begin
    win      = dir_q ? shreg_q[STEP-1:0] : shreg_q[XLEN-1 -: STEP];
    win_zero = (win == '0);
    lz       = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (!found) begin
        if (dir_q ? win[i] : win[int'(STEP) - 1 - i]) begin
          found = 1'b1;
        end else begin
          lz = lz + CW'(1);
        end
      end
    end
    amt = win_zero ? CW'(STEP) : lz;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (bus_io.i_valid) begin
          dir_d = bus_io.i_direction;
          if (bus_io.i_a == '0) begin
            shreg_d = '0;
            count_d = CW'(XLEN);
            zero_d  = 1'b1;
            state_d = StDone;
          end else begin
            shreg_d = bus_io.i_a;
            count_d = '0;
            zero_d  = 1'b0;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        shreg_d = dir_q ? (shreg_q >> amt) : (shreg_q << amt);
        count_d = count_q + amt;
        if (!win_zero) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

  assign bus_io.o_ready  = (state_q == StIdle);
  assign bus_io.o_valid  = (state_q == StDone);
  assign bus_io.o_count  = count_q;
  assign bus_io.o_result = shreg_q;
  assign bus_io.o_zero   = zero_q;
endmodule

// File: tb/tb_alu_normalize.sv
// Directed bench for alu_normalize: hand-computed vectors, latency, DONE hold,
// mid-scan reset, plus a short run of random operands against a bit-loop model.
module tb_alu_normalize;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_normalize_if #(.XLEN(32)) bus ();

  alu_normalize #(
    .XLEN(32),
    .STEP(4)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic int zeros_model(input logic [31:0] a, input logic dir);
    int c;
    c = 0;
    if (dir) begin
      for (int i = 0; i < 32; i++) begin
        if (a[i]) break;
        c++;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (a[i]) break;
        c++;
      end
    end
    return c;
  endfunction

  // One full transaction: accept, wait for o_valid, hold DONE for `stall` cycles
  // while pushing ignored requests, then release and check return to idle.
  task automatic run(input string tag, input logic [31:0] a, input logic dir,
                     input int exp_cnt, input logic [31:0] exp_res, input logic exp_zero,
                     input int exp_e, input int stall);
    int e;
    logic [40:0] held;
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_a         = a;
    bus.i_direction = dir;
    bus.i_ready     = 1'b0;
    @(posedge clk);
    #1;
    e = 1;
    bus.i_valid     = 1'b0;
    bus.i_a         = ~a;
    bus.i_direction = ~dir;
    while (!bus.o_valid && e < 60) begin
      @(posedge clk);
      #1;
      e++;
    end
    check({tag, " latency"}, 64'(e), 64'(exp_e));
    check({tag, " count"}, 64'(bus.o_count), 64'(exp_cnt));
    check({tag, " result"}, 64'(bus.o_result), 64'(exp_res));
    check({tag, " zero"}, 64'(bus.o_zero), 64'(exp_zero));
    check({tag, " ready in done"}, 64'(bus.o_ready), 64'(0));
    held = {1'b1, 1'b0, 6'(exp_cnt), exp_res, exp_zero};
    for (int s = 0; s < stall; s++) begin
      bus.i_valid     = 1'b1;
      bus.i_a         = $urandom;
      bus.i_direction = 1'($urandom);
      @(posedge clk);
      #1;
      check({tag, " hold"}, 64'({bus.o_valid, bus.o_ready, bus.o_count, bus.o_result,
                                 bus.o_zero}), 64'(held));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, " release"}, 64'({bus.o_ready, bus.o_valid}), 64'(2'b10));
  endtask

  initial begin
    logic [31:0] ra;
    logic        rd;
    int          rc;
    logic [31:0] rr;
    logic        seen_valid;
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_a         = '0;
    bus.i_direction = 1'b0;
    bus.i_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset ready", 64'(bus.o_ready), 64'(1));
    check("reset valid", 64'(bus.o_valid), 64'(0));
    check("reset count", 64'(bus.o_count), 64'(0));
    check("reset result", 64'(bus.o_result), 64'(0));
    check("reset zero", 64'(bus.o_zero), 64'(0));

    run("t1 0x1000 left", 32'h0000_1000, 1'b0, 19, 32'h8000_0000, 1'b0, 6, 0);
    run("t2 0x1000 right", 32'h0000_1000, 1'b1, 12, 32'h0000_0001, 1'b0, 5, 0);
    run("t3 zero left", 32'h0, 1'b0, 32, 32'h0, 1'b1, 1, 0);
    run("t3 zero right", 32'h0, 1'b1, 32, 32'h0, 1'b1, 1, 0);
    run("t4 msb left", 32'h8000_0000, 1'b0, 0, 32'h8000_0000, 1'b0, 2, 0);
    run("t4 msb right", 32'h8000_0000, 1'b1, 31, 32'h0000_0001, 1'b0, 9, 0);
    run("t5 stall", 32'h0003_0000, 1'b0, 14, 32'hC000_0000, 1'b0, 5, 5);
    run("t5 after", 32'h0000_0050, 1'b1, 4, 32'h0000_0005, 1'b0, 3, 0);
    run("lsb right", 32'h0000_0001, 1'b1, 0, 32'h0000_0001, 1'b0, 2, 1);

    // Reset two edges into a long scan; the abandoned op must never report.
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_a         = 32'h0000_0001;
    bus.i_direction = 1'b0;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6 reset ready", 64'(bus.o_ready), 64'(1));
    check("t6 reset valid", 64'(bus.o_valid), 64'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen_valid |= bus.o_valid;
    end
    check("t6 no stale valid", 64'(seen_valid), 64'(0));
    run("t6 0xFF left", 32'h0000_00FF, 1'b0, 24, 32'hFF00_0000, 1'b0, 8, 0);

    for (int n = 0; n < 16; n++) begin
      ra = $urandom >> $urandom_range(0, 31);
      ra = ra << $urandom_range(0, 31);
      rd = 1'($urandom);
      if (ra == 0) begin
        run("rand zero", ra, rd, 32, 32'h0, 1'b1, 1, $urandom_range(0, 3));
      end else begin
        rc = zeros_model(ra, rd);
        rr = rd ? (ra >> rc) : (ra << rc);
        run("rand", ra, rd, rc, rr, 1'b0, rc / 4 + 2, $urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
